// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and bit-timing helper for uart_recv / uart_send.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BIT, PARITY_BIT, STOP_BIT, WAIT_IDLE
  } uart_state_t;
  function automatic int cycles_wait(input int clock_mhz, input int baud);
    return clock_mhz * 1000000 / baud;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, with a reset value parameter.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge clk) r_ff <= rst ? {2{RST_VAL}} : {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver (8E1 with even parity when UART_RX_PARITY_EN is defined).
module uart_recv
  import uart_pkg::*;
#(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_SPEED_MHZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       framing_err,
  output logic       parity_err,
  output logic       busy
);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [15:0] CW = 16'(cycles_wait(CLOCK_SPEED_MHZ, BAUD_RATE));
  localparam logic [15:0] HW = CW >> 1;
  uart_state_t r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift, r_data_byte;
  logic        r_valid, r_ferr, r_perr, r_par_mis, r_rx_d;
  logic        w_rx_s;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .i_d(rx), .o_q(w_rx_s));
  // Sampling points sit mid-bit; IDLE is re-entered at mid-stop so back-to-back frames are caught.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data_byte <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_perr      <= 1'b0;
      r_par_mis   <= 1'b0;
      r_rx_d      <= 1'b1;
    end else begin
      r_rx_d  <= w_rx_s;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      case (r_state)
        IDLE: if (r_rx_d && !w_rx_s) begin
          r_state   <= START_BIT;
          r_cnt     <= '0;
          r_par_mis <= 1'b0;
        end
        START_BIT: if (r_cnt == HW) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= w_rx_s ? IDLE : DATA_BIT;
        end else r_cnt <= r_cnt + 16'd1;
        DATA_BIT: if (r_cnt == CW) begin
          r_cnt          <= '0;
          r_shift[r_idx] <= w_rx_s;
          r_idx          <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= PAR_EN ? PARITY_BIT : STOP_BIT;
        end else r_cnt <= r_cnt + 16'd1;
        PARITY_BIT: if (r_cnt == CW) begin
          r_cnt     <= '0;
          r_par_mis <= w_rx_s != ^r_shift;
          r_state   <= STOP_BIT;
        end else r_cnt <= r_cnt + 16'd1;
        STOP_BIT: if (r_cnt == CW) begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_ferr  <= 1'b1;
            r_state <= WAIT_IDLE;
          end else if (r_par_mis) begin
            r_perr  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_data_byte <= r_shift;
            r_valid     <= 1'b1;
            r_state     <= IDLE;
          end
        end else r_cnt <= r_cnt + 16'd1;
        WAIT_IDLE: if (w_rx_s) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign data_byte   = r_data_byte;
  assign data_valid  = r_valid;
  assign framing_err = r_ferr;
  assign parity_err  = PAR_EN ? r_perr : 1'b0;
  assign busy        = r_state != IDLE;
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: directed bench for uart_recv at 9600 baud on a 1 MHz clock (bit = 105 cycles).
module tb_uart_recv;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int CW  = 104;
  localparam int HW  = 52;
  localparam int BIT = CW + 1;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] data_byte;
  logic data_valid, framing_err, parity_err, busy;
  int n_tests = 0, n_fail = 0;
  int n_dv = 0, n_fe = 0, n_pe = 0, n_ovl = 0;
  logic [7:0] q[$];
  uart_recv #(.BAUD_RATE(9600), .CLOCK_SPEED_MHZ(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_byte(data_byte), .data_valid(data_valid),
    .framing_err(framing_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (data_valid) begin
      n_dv++;
      q.push_back(data_byte);
    end
    if (framing_err) n_fe++;
    if (parity_err) n_pe++;
    if (int'(data_valid) + int'(framing_err) + int'(parity_err) > 1) n_ovl++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end
  task automatic send_bits(input logic [7:0] b, input logic stop_v, input logic par_v, input logic use_par);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (use_par) begin
      rx = par_v;
      repeat (BIT) @(negedge clk);
    end
    rx = stop_v;
    repeat (BIT) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b1, ^b, PAR);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    n_tests += 5;
    if (data_byte !== 8'h00) begin n_fail++; $display("FAIL reset_data_byte: got %h, required 00", data_byte); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
    if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_framing_err: got %b, required 0", framing_err); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b, required 0", parity_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask
  task automatic test_basic;
    int dv0, fe0, pe0;
    dv0 = n_dv; fe0 = n_fe; pe0 = n_pe;
    send_frame(8'h46);
    repeat (2 * BIT) @(negedge clk);
    n_tests += 5;
    if (n_dv - dv0 !== 1) begin n_fail++; $display("FAIL basic_dv_count: got %0d, required 1", n_dv - dv0); end
    if (data_byte !== 8'h46) begin n_fail++; $display("FAIL basic_data: got %h, required 46", data_byte); end
    if (q.size() == 0 || q[q.size()-1] !== 8'h46) begin n_fail++; $display("FAIL basic_pulse_data: got size %0d, required last byte 46", q.size()); end
    if (n_fe - fe0 + n_pe - pe0 !== 0) begin n_fail++; $display("FAIL basic_err_pulses: got %0d, required 0", n_fe - fe0 + n_pe - pe0); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
  endtask
  task automatic test_glitch;
    int sum0, t;
    sum0 = n_dv + n_fe + n_pe;
    rx = 1'b0;
    repeat (HW / 5) @(negedge clk);
    rx = 1'b1;
    n_tests += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b, required 1", busy); end
    t = HW / 5;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t > HW + 20) begin n_fail++; $display("FAIL glitch_idle_time: got %0d cycles, required <= %0d", t, HW + 20); end
    repeat (2 * BIT) @(negedge clk);
    if (n_dv + n_fe + n_pe !== sum0) begin n_fail++; $display("FAIL glitch_pulses: got %0d, required 0", n_dv + n_fe + n_pe - sum0); end
  endtask
  task automatic test_framing;
    int dv0, fe0;
    dv0 = n_dv; fe0 = n_fe;
    send_bits(8'hA5, 1'b0, ^8'hA5, PAR);
    repeat (3 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    n_tests += 3;
    if (n_fe - fe0 !== 1) begin n_fail++; $display("FAIL framing_count: got %0d, required 1", n_fe - fe0); end
    if (n_dv - dv0 !== 0) begin n_fail++; $display("FAIL framing_dv: got %0d, required 0", n_dv - dv0); end
    if (data_byte !== 8'h46) begin n_fail++; $display("FAIL framing_keep_data: got %h, required 46", data_byte); end
    dv0 = n_dv;
    send_frame(8'h3C);
    repeat (2 * BIT) @(negedge clk);
    n_tests += 2;
    if (n_dv - dv0 !== 1) begin n_fail++; $display("FAIL after_framing_dv: got %0d, required 1", n_dv - dv0); end
    if (data_byte !== 8'h3C) begin n_fail++; $display("FAIL after_framing_data: got %h, required 3c", data_byte); end
  endtask
  task automatic test_back_to_back;
    int n0;
    n0 = q.size();
    send_frame(8'h00);
    send_frame(8'hFF);
    repeat (2 * BIT) @(negedge clk);
    n_tests += 3;
    if (q.size() - n0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d, required 2", q.size() - n0); end
    if (q.size() < n0 + 2 || q[n0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got size %0d, required first byte 00", q.size()); end
    if (q.size() < n0 + 2 || q[n0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got size %0d, required second byte ff", q.size()); end
  endtask
  task automatic test_reset_mid;
    int sum0, dv0;
    logic [7:0] b;
    b = 8'h55;
    sum0 = n_dv + n_fe + n_pe;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    n_tests += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    repeat (12 * BIT) @(negedge clk);
    if (n_dv + n_fe + n_pe !== sum0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d, required 0", n_dv + n_fe + n_pe - sum0); end
    dv0 = n_dv;
    send_frame(8'h55);
    repeat (2 * BIT) @(negedge clk);
    n_tests += 2;
    if (n_dv - dv0 !== 1) begin n_fail++; $display("FAIL rstmid_dv: got %0d, required 1", n_dv - dv0); end
    if (data_byte !== 8'h55) begin n_fail++; $display("FAIL rstmid_data: got %h, required 55", data_byte); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int dv0, pe0;
    dv0 = n_dv; pe0 = n_pe;
    send_bits(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    n_tests += 3;
    if (n_pe - pe0 !== 1) begin n_fail++; $display("FAIL parity_err_count: got %0d, required 1", n_pe - pe0); end
    if (n_dv - dv0 !== 0) begin n_fail++; $display("FAIL parity_bad_dv: got %0d, required 0", n_dv - dv0); end
    if (data_byte !== 8'h55) begin n_fail++; $display("FAIL parity_keep_data: got %h, required 55", data_byte); end
    dv0 = n_dv;
    send_bits(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    n_tests += 2;
    if (n_dv - dv0 !== 1) begin n_fail++; $display("FAIL parity_good_dv: got %0d, required 1", n_dv - dv0); end
    if (data_byte !== 8'h07) begin n_fail++; $display("FAIL parity_good_data: got %h, required 07", data_byte); end
  endtask
`endif
  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    n_tests++;
    if (n_ovl !== 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d overlaps, required 0", n_ovl); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
